cursor_controller: RTL and testbench



---
 rtl/cursor_pkg.sv | 35 +++
 rtl/button_debouncer.sv | 30 +++
 rtl/cursor_controller.sv | 136 +++++++++++++
 tb/tb_cursor_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cursor_pkg.sv
// Shared types, limits and the per-axis step helper for the cursor controller.
package cursor_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} repeat_state_t;

  // {up, down, left, right}
  typedef logic [3:0] dir_t;

  localparam int LIM_MIN   = 2;   // plus shape arm length keeps the centre 2 px off the edge
  localparam int LIM_INSET = 3;   // max limit is RES - LIM_INSET
  localparam int RPT_W     = 8;   // repeat frame counter width
  localparam int STEP_W    = 16;  // position arithmetic width, wider than any port

  function automatic int lim_max(input int res);
    return res - LIM_INSET;
  endfunction

  // One step along an axis; a step past a limit clamps, and a step from the limit
  // itself wraps to the opposite limit when wrap is set.
  function automatic logic [STEP_W-1:0] axis_step(
    input logic [STEP_W-1:0] p, lo, hi, stp,
    input logic inc, dec, wrap);
    axis_step = p;
    if (inc) begin
      if (p == hi)            axis_step = wrap ? lo : hi;
      else if (p + stp > hi)  axis_step = hi;
      else                    axis_step = p + stp;
    end else if (dec) begin
      if (p == lo)            axis_step = wrap ? hi : lo;
      else if (p < lo + stp)  axis_step = lo;
      else                    axis_step = p - stp;
    end
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// 2-FF synchronizer plus stability counter; level follows the input only after
// DEBOUNCE_CYCLES consecutive cycles at the new synchronized value.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/cursor_controller.sv
// Button-driven, frame-synchronous cursor with auto-repeat and cell-toggle requests.
// Define CURSOR_WRAP_EN to wrap at the screen limits instead of clamping.
module cursor_controller
  import cursor_pkg::*;
#(
  parameter int H_RES               = 640,
  parameter int V_RES               = 480,
  parameter int CELL_SIZE           = 8,
  parameter int DEBOUNCE_CYCLES     = 250000,
  parameter int REPEAT_DELAY_FRAMES = 20,
  parameter int REPEAT_RATE_FRAMES  = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 frameStart,
  input  logic                                 btnUp,
  input  logic                                 btnDown,
  input  logic                                 btnLeft,
  input  logic                                 btnRight,
  input  logic                                 btnSelect,
  input  logic                                 editEnable,
  output logic [$clog2(H_RES)-1:0]             cursorX,
  output logic [$clog2(V_RES)-1:0]             cursorY,
  output logic                                 cellToggle,
  output logic [$clog2(H_RES/CELL_SIZE)-1:0]   cellX,
  output logic [$clog2(V_RES/CELL_SIZE)-1:0]   cellY
);
  localparam int XW  = $clog2(H_RES);
  localparam int YW  = $clog2(V_RES);
  localparam int CXW = $clog2(H_RES/CELL_SIZE);
  localparam int CYW = $clog2(V_RES/CELL_SIZE);

  localparam logic [STEP_W-1:0] XLO  = STEP_W'(LIM_MIN);
  localparam logic [STEP_W-1:0] XHI  = STEP_W'(lim_max(H_RES));
  localparam logic [STEP_W-1:0] YLO  = STEP_W'(LIM_MIN);
  localparam logic [STEP_W-1:0] YHI  = STEP_W'(lim_max(V_RES));
  localparam logic [STEP_W-1:0] STEP = STEP_W'(CELL_SIZE);
  localparam logic [RPT_W-1:0]  DLY  = RPT_W'(REPEAT_DELAY_FRAMES);
  localparam logic [RPT_W-1:0]  RATE = RPT_W'(REPEAT_RATE_FRAMES);

`ifdef CURSOR_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  logic [4:0] raw, db;
  assign raw = {btnSelect, btnUp, btnDown, btnLeft, btnRight};

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [4:0] (
    .clk(clk), .reset(reset), .btn(raw), .level(db));

  // Opposing buttons on one axis cancel that axis.
  dir_t dir;
  assign dir = {(db[3] ^ db[2]) ? db[3:2] : 2'b00,
                (db[1] ^ db[0]) ? db[1:0] : 2'b00};

  repeat_state_t state_q, state_d;
  logic [RPT_W-1:0] cnt_q, cnt_d;
  dir_t last_q, last_d;
  logic move;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    move    = 1'b0;
    if (frameStart) begin
      unique case (state_q)
        IDLE: if (dir != '0) begin
          move = 1'b1; last_d = dir; cnt_d = DLY; state_d = DELAY;
        end
        DELAY: begin
          if (dir == '0) state_d = IDLE;
          else if (dir != last_q) begin
            move = 1'b1; last_d = dir; cnt_d = DLY;
          end else if (cnt_q == RPT_W'(1)) begin
            move = 1'b1; cnt_d = RATE; state_d = REPEAT;
          end else cnt_d = cnt_q - 1'b1;
        end
        REPEAT: begin
          if (dir == '0) state_d = IDLE;
          else if (dir != last_q) begin
            move = 1'b1; last_d = dir; cnt_d = DLY; state_d = DELAY;
          end else if (cnt_q == RPT_W'(1)) begin
            move = 1'b1; cnt_d = RATE;
          end else cnt_d = cnt_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  logic [STEP_W-1:0] nx, ny;
  assign nx = axis_step(STEP_W'(cursorX), XLO, XHI, STEP, dir[0], dir[1], WRAP);
  assign ny = axis_step(STEP_W'(cursorY), YLO, YHI, STEP, dir[2], dir[3], WRAP);

  // Select is sampled against the registered position, so a coincident move
  // reports the pre-move cell.
  logic sel_q, sel_rise;
  assign sel_rise = db[4] & ~sel_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cursorX    <= XW'(H_RES/2);
      cursorY    <= YW'(V_RES/2);
      sel_q      <= 1'b0;
      cellToggle <= 1'b0;
      cellX      <= '0;
      cellY      <= '0;
    end else begin
      if (move) begin
        cursorX <= nx[XW-1:0];
        cursorY <= ny[YW-1:0];
      end
      sel_q      <= db[4];
      cellToggle <= sel_rise & editEnable;
      if (sel_rise & editEnable) begin
        cellX <= CXW'(cursorX / CELL_SIZE);
        cellY <= CYW'(cursorY / CELL_SIZE);
      end
    end
  end
endmodule

// File: tb/tb_cursor_controller.sv
// Scoreboard bench for cursor_controller: stimulus queues expected moves/toggles,
// a monitor pops and compares whenever the cursor changes or a toggle fires.
module tb_cursor_controller;
  localparam int FP = 16;  // clocks per frame

  logic clk, reset, frameStart;
  logic btnUp, btnDown, btnLeft, btnRight, btnSelect, editEnable;
  logic [9:0] cursorX;
  logic [8:0] cursorY;
  logic cellToggle;
  logic [6:0] cellX;
  logic [5:0] cellY;

  cursor_controller #(
    .H_RES(640), .V_RES(480), .CELL_SIZE(8), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY_FRAMES(3), .REPEAT_RATE_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .frameStart(frameStart),
    .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft), .btnRight(btnRight),
    .btnSelect(btnSelect), .editEnable(editEnable),
    .cursorX(cursorX), .cursorY(cursorY), .cellToggle(cellToggle),
    .cellX(cellX), .cellY(cellY));

  typedef struct {bit tog; int a; int b; int fr;} ev_t;
  ev_t exq[$];
  int vecs = 0, errs = 0, mcnt = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end

  initial begin
    frameStart = 0;
    forever begin
      repeat (FP-1) @(negedge clk);
      frameStart = 1;
      @(negedge clk);
      frameStart = 0;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic push_move(input int x, input int y, input int fr);
    ev_t e; e.tog = 0; e.a = x; e.b = y; e.fr = fr; exq.push_back(e);
  endtask

  task automatic push_tog(input int cx, input int cy);
    ev_t e; e.tog = 1; e.a = cx; e.b = cy; e.fr = 0; exq.push_back(e);
  endtask

  task automatic wait_frame();
    @(posedge clk iff frameStart);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1;
    #1;
    chk("reset_x", int'(cursorX), 320);
    chk("reset_y", int'(cursorY), 240);
    chk("reset_toggle", int'(cellToggle), 0);
    @(negedge clk);
    reset = 0;
  endtask

  // Monitor
  initial begin
    int px, py;
    ev_t e;
    px = 320; py = 240;
    forever begin
      @(posedge clk); #1;
      if (frameStart) mcnt++;
      if (reset) begin px = cursorX; py = cursorY; continue; end
      if (int'(cursorX) != px || int'(cursorY) != py) begin
        vecs++;
        if (exq.size() == 0) begin
          errs++;
          $display("FAIL unexpected_move: got (%0d,%0d) frame %0d, expected no move", cursorX, cursorY, mcnt);
        end else begin
          e = exq.pop_front();
          if (e.tog || int'(cursorX) != e.a || int'(cursorY) != e.b || mcnt != e.fr || !frameStart) begin
            errs++;
            $display("FAIL move: got tog=0 (%0d,%0d) frame %0d fs=%0b, expected tog=%0d (%0d,%0d) frame %0d fs=1",
                     cursorX, cursorY, mcnt, frameStart, e.tog, e.a, e.b, e.fr);
          end
        end
        px = cursorX; py = cursorY;
      end
      if (cellToggle) begin
        vecs++;
        if (exq.size() == 0) begin
          errs++;
          $display("FAIL unexpected_toggle: got cell (%0d,%0d), expected no toggle", cellX, cellY);
        end else begin
          e = exq.pop_front();
          if (!e.tog || int'(cellX) != e.a || int'(cellY) != e.b) begin
            errs++;
            $display("FAIL toggle: got tog=1 cell (%0d,%0d), expected tog=%0d (%0d,%0d)",
                     cellX, cellY, e.tog, e.a, e.b);
          end
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    errs++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $fatal(1, "timeout");
  end

  initial begin
    int f;
    int rel3[3];
    int rel5[5];
    reset = 1; btnUp = 0; btnDown = 0; btnLeft = 0; btnRight = 0;
    btnSelect = 0; editEnable = 0;
    repeat (3) @(negedge clk);
    chk("rst_cursorX", int'(cursorX), 320);
    chk("rst_cursorY", int'(cursorY), 240);
    chk("rst_cellToggle", int'(cellToggle), 0);
    chk("rst_cellX", int'(cellX), 0);
    chk("rst_cellY", int'(cellY), 0);
    reset = 0;

    // single right step, then a short glitch on left
    wait_frame();
    push_move(328, 240, mcnt + 1);
    btnRight = 1;
    wait_frame();
    btnRight = 0;
    repeat (3) @(negedge clk);
    btnLeft = 1;
    repeat (2) @(negedge clk);
    btnLeft = 0;
    repeat (3) wait_frame();
    chk("glitch_x", int'(cursorX), 328);

    // select: one pulse while enabled, none while disabled
    editEnable = 1;
    push_tog(41, 30);
    btnSelect = 1;
    repeat (20) @(negedge clk);
    btnSelect = 0;
    repeat (10) @(negedge clk);
    editEnable = 0;
    btnSelect = 1;
    repeat (20) @(negedge clk);
    btnSelect = 0;
    repeat (10) @(negedge clk);
    chk("cellX_hold", int'(cellX), 41);
    chk("cellY_hold", int'(cellY), 30);

    // up+down cancel, then down alone moves
    wait_frame();
    btnUp = 1; btnDown = 1;
    repeat (5) wait_frame();
    push_move(328, 248, mcnt + 1);
    btnUp = 0;
    wait_frame();
    btnDown = 0;
    repeat (2) wait_frame();

    pulse_reset();

    // held right for 10 frames: moves at relative frames 0,3,5,7,9
    rel5 = '{0, 3, 5, 7, 9};
    wait_frame();
    f = mcnt;
    for (int i = 0; i < 5; i++) push_move(328 + 8*i, 240, f + 1 + rel5[i]);
    btnRight = 1;
    repeat (10) wait_frame();
    btnRight = 0;
    repeat (2) wait_frame();
    chk("repeat_x", int'(cursorX), 360);

    // held left from 360: 44 steps to 8, 45th clamps to 2
    wait_frame();
    f = mcnt;
    for (int k = 0; k < 45; k++)
      push_move((k < 44) ? 352 - 8*k : 2, 240, f + 1 + ((k == 0) ? 0 : 2*k + 1));
    btnLeft = 1;
    repeat (90) wait_frame();
    btnLeft = 0;
    repeat (2) wait_frame();
    chk("clamp_x", int'(cursorX), 2);

    // one more left press at the limit
    wait_frame();
`ifdef CURSOR_WRAP_EN
    push_move(637, 240, mcnt + 1);
`endif
    btnLeft = 1;
    wait_frame();
    btnLeft = 0;
    repeat (2) wait_frame();
`ifdef CURSOR_WRAP_EN
    chk("limit_x", int'(cursorX), 637);
`else
    chk("limit_x", int'(cursorX), 2);
`endif

    // reset while in REPEAT; next press must use the full delay
    pulse_reset();
    rel3 = '{0, 3, 5};
    wait_frame();
    f = mcnt;
    for (int i = 0; i < 3; i++) push_move(328 + 8*i, 240, f + 1 + rel3[i]);
    btnRight = 1;
    repeat (6) wait_frame();
    btnRight = 0;
    pulse_reset();
    wait_frame();
    f = mcnt;
    push_move(328, 240, f + 1);
    push_move(336, 240, f + 4);
    btnRight = 1;
    repeat (5) wait_frame();
    btnRight = 0;
    repeat (2) wait_frame();
    chk("post_reset_x", int'(cursorX), 336);

    chk("queue_empty", exq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
